// File: rtl/cnn_maxp_pkg.sv
// Shared definitions for the streaming max-pooling block: compare modes,
// the float ordering key and the pipeline latency.
package cnn_maxp_pkg;

    localparam int MODE_INT  = 0;
    localparam int MODE_FP32 = 1;

    // Maps an IEEE-754 word onto an unsigned key with total order -NaN < -inf < ... < -0 < +0 < ... < +NaN.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        logic [31:0] key;
        if (x[31]) begin
            key = ~x;
        end else begin
            key = {1'b1, x[30:0]};
        end
        return key;
    endfunction

    function automatic int maxp_lat(input int k);
        return 1 + $clog2(k * k);
    endfunction

endpackage

// File: rtl/cnn_maxp_cmp2.sv
// One registered node of the max tree: picks the larger valid input, input a on ties.
module cnn_maxp_cmp2
    import cnn_maxp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = MODE_FP32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  b_valid,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  y_valid
);

    logic b_greater_s;
    logic sel_b_s;

    generate
        if (MODE == MODE_FP32) begin : g_fp
            assign b_greater_s = fp32_key(b) > fp32_key(a);
        end else begin : g_int
            assign b_greater_s = $signed(b) > $signed(a);
        end
    endgenerate

    // Input selection: a masked-out operand never wins.
    always_comb begin
        sel_b_s = 1'b0;
        if (a_valid && b_valid) begin
            sel_b_s = b_greater_s;
        end else if (b_valid) begin
            sel_b_s = 1'b1;
        end else begin
            sel_b_s = 1'b0;
        end
    end

    // Node register.
    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y       <= sel_b_s ? b : a;
            y_valid <= a_valid | b_valid;
        end
    end

endmodule

// File: rtl/cnn_maxp_multi_channel.sv
// Streaming K x K / stride S max pooling over channel-sequential raster input,
// with a line buffer shared by all channels and a registered binary compare tree.
module cnn_maxp_multi_channel
    import cnn_maxp_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int IMAGE_WIDTH    = 16,
    parameter int IMAGE_HEIGHT   = 16,
    parameter int CHANNEL_NUM_IN = 4,
    parameter int KERNEL         = 3,
    parameter int STRIDE         = 2,
    parameter int MODE           = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int TAPS  = KERNEL * KERNEL;
    localparam int DEPTH = maxp_lat(KERNEL) - 1;
    localparam int NL    = 1 << DEPTH;
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CH_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

    logic [COL_W-1:0]      col_r;
    logic [ROW_W-1:0]      row_r;
    logic [CH_W-1:0]       ch_r;
    logic                  col_last_s, row_last_s, ch_last_s;
    logic                  emit_s;
    logic [DATA_WIDTH-1:0] lb_r   [0:KERNEL-2][0:IMAGE_WIDTH-1];
    logic [DATA_WIDTH-1:0] colv_s [0:KERNEL-1];
    logic [KERNEL-1:0]     colm_s;
    logic [DATA_WIDTH-1:0] win_d_r [0:TAPS-1];
    logic [TAPS-1:0]       win_v_r;
    logic [DEPTH:0]        tag_v_r, tag_l_r;
    logic [DATA_WIDTH-1:0] node_d_s [1:2*NL-1];
    logic                  node_v_s [1:2*NL-1];

    assign col_last_s = (col_r == COL_W'(IMAGE_WIDTH - 1));
    assign row_last_s = (row_r == ROW_W'(IMAGE_HEIGHT - 1));
    assign ch_last_s  = (ch_r == CH_W'(CHANNEL_NUM_IN - 1));
    assign emit_s     = valid_in && ((int'(row_r) % STRIDE) == STRIDE - 1)
                                 && ((int'(col_r) % STRIDE) == STRIDE - 1);

    // Position counters, advanced by accepted pixels only.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
            ch_r  <= '0;
        end else if (valid_in) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                    ch_r  <= ch_last_s ? CH_W'(0) : ch_r + CH_W'(1);
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Line buffer: slot j of a column holds the pixel j+1 rows above the current one.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb_r[0][col_r] <= pxl_in;
            for (int j = 1; j < KERNEL - 1; j++) begin
                lb_r[j][col_r] <= lb_r[j-1][col_r];
            end
        end
    end

    // Incoming window column, top row first; rows above the channel's row 0 are padding.
    always_comb begin
        colm_s = '0;
        for (int i = 0; i < KERNEL - 1; i++) begin
            colv_s[i] = lb_r[KERNEL-2-i][col_r];
            colm_s[i] = (int'(row_r) >= KERNEL - 1 - i);
        end
        colv_s[KERNEL-1] = pxl_in;
        colm_s[KERNEL-1] = 1'b1;
    end

    // Window register, raster tap order; at column 0 the older columns belong to the previous row.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_v_r <= '0;
        end else if (valid_in) begin
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL - 1; j++) begin
                    win_d_r[i*KERNEL+j] <= win_d_r[i*KERNEL+j+1];
                    win_v_r[i*KERNEL+j] <= (col_r == COL_W'(0)) ? 1'b0 : win_v_r[i*KERNEL+j+1];
                end
                win_d_r[i*KERNEL+KERNEL-1] <= colv_s[i];
                win_v_r[i*KERNEL+KERNEL-1] <= colm_s[i];
            end
        end
    end

    // Window valid / last tags travel alongside the tree, independent of valid_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_r <= '0;
            tag_l_r <= '0;
        end else begin
            tag_v_r <= {tag_v_r[DEPTH-1:0], emit_s};
            tag_l_r <= {tag_l_r[DEPTH-1:0], emit_s && ch_last_s && row_last_s && col_last_s};
        end
    end

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : g_leaf
            if (g < TAPS) begin : g_tap
                assign node_d_s[NL+g] = win_d_r[g];
                assign node_v_s[NL+g] = win_v_r[g];
            end else begin : g_pad
                assign node_d_s[NL+g] = '0;
                assign node_v_s[NL+g] = 1'b0;
            end
        end
        // Heap-ordered tree: the left child always covers earlier taps, so ties keep raster order.
        for (g = 1; g < NL; g++) begin : g_node
            cnn_maxp_cmp2 #(
                .DATA_WIDTH(DATA_WIDTH),
                .MODE      (MODE)
            ) u_cmp (
                .clk    (clk),
                .reset  (reset),
                .a      (node_d_s[2*g]),
                .a_valid(node_v_s[2*g]),
                .b      (node_d_s[2*g+1]),
                .b_valid(node_v_s[2*g+1]),
                .y      (node_d_s[g]),
                .y_valid(node_v_s[g])
            );
        end
    endgenerate

    // Output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out   <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= tag_v_r[DEPTH] & node_v_s[1];
            last_out  <= tag_l_r[DEPTH];
            if (tag_v_r[DEPTH]) begin
                pxl_out <= node_d_s[1];
            end
        end
    end

endmodule

// File: tb/tb_cnn_maxp_multi_channel.sv
// Directed bench for cnn_maxp_multi_channel: a window-level reference model
// predicts every pooled word, its last flag and its arrival cycle.
module tb_cnn_maxp_multi_channel;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic [2:0]       rst, vin, vout, lout;
    logic [2:0][31:0] pin, pout;
    exp_t             expq [3][$];
    int               tq   [3][$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    logic [31:0]      frame [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // inst 0: 16x16x4 K3 S2 int, inst 1: 4x4x1 K3 S2 float, inst 2: 4x4x1 K2 S2 int
    cnn_maxp_multi_channel #(.DATA_WIDTH(32), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16),
        .CHANNEL_NUM_IN(4), .KERNEL(3), .STRIDE(2), .MODE(0)) u_int (
        .clk(clk), .reset(rst[0]), .valid_in(vin[0]), .pxl_in(pin[0]),
        .pxl_out(pout[0]), .valid_out(vout[0]), .last_out(lout[0]));
    cnn_maxp_multi_channel #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(1), .KERNEL(3), .STRIDE(2), .MODE(1)) u_fp (
        .clk(clk), .reset(rst[1]), .valid_in(vin[1]), .pxl_in(pin[1]),
        .pxl_out(pout[1]), .valid_out(vout[1]), .last_out(lout[1]));
    cnn_maxp_multi_channel #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(1), .KERNEL(2), .STRIDE(2), .MODE(0)) u_k2 (
        .clk(clk), .reset(rst[2]), .valid_in(vin[2]), .pxl_in(pin[2]),
        .pxl_out(pout[2]), .valid_out(vout[2]), .last_out(lout[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Numeric ordering: signed integers, or IEEE-754 by sign then magnitude (-0 below +0).
    function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input int fp);
        if (fp == 0) return $signed(a) > $signed(b);
        if (a[31] != b[31]) return b[31];
        if (a[31] == 1'b0) return a > b;
        return a < b;
    endfunction

    task automatic model(input int inst, input int w, input int h, input int c,
                         input int k, input int s, input int fp);
        int p;
        p = k - s;
        for (int ch = 0; ch < c; ch++)
            for (int oy = 0; oy < h / s; oy++)
                for (int ox = 0; ox < w / s; ox++) begin
                    logic [31:0] best;
                    bit          have;
                    exp_t        e;
                    best = 32'd0;
                    have = 1'b0;
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            int y, x;
                            y = oy * s - p + ky;
                            x = ox * s - p + kx;
                            if (y >= 0 && x >= 0) begin
                                if (!have || gt(frame[ch*w*h + y*w + x], best, fp)) begin
                                    best = frame[ch*w*h + y*w + x];
                                    have = 1'b1;
                                end
                            end
                        end
                    e.d    = best;
                    e.last = (ch == c - 1) && (oy == h / s - 1) && (ox == w / s - 1);
                    expq[inst].push_back(e);
                end
    endtask

    // gapmode 1: alternate idle cycles for the first half, random 0..3 idle cycles after.
    task automatic send(input int inst, input int w, input int h, input int s,
                        input int k, input int stop, input int gapmode);
        int lat;
        lat = 1 + $clog2(k * k);
        for (int i = 0; i < stop; i++) begin
            int gap, r, cl;
            gap = 0;
            if (gapmode != 0) gap = (i < stop / 2) ? 1 : int'($urandom_range(3, 0));
            repeat (gap) begin
                @(posedge clk); #1;
                vin[inst] = 1'b0;
            end
            @(posedge clk); #1;
            vin[inst] = 1'b1;
            pin[inst] = frame[i];
            r  = (i % (w * h)) / w;
            cl = i % w;
            if ((r % s == s - 1) && (cl % s == s - 1)) tq[inst].push_back(cyc + 1 + lat);
        end
        @(posedge clk); #1;
        vin[inst] = 1'b0;
    endtask

    task automatic drain(input int inst);
        int n;
        n = 0;
        while (expq[inst].size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check($sformatf("drain_outputs_%0d", inst), expq[inst].size(), 32'd0);
        check($sformatf("drain_times_%0d", inst), tq[inst].size(), 32'd0);
    endtask

    task automatic ramp_frame();
        frame.delete();
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 256; i++) frame.push_back(i + 1000 * ch);
    endtask

    // Every valid_out is matched against the model's next word, last flag and arrival cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vout[i]) begin
                if (expq[i].size() == 0 || tq[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid_out_%0d: got pxl_out %h, required no output", i, pout[i]);
                end else begin
                    exp_t e;
                    int   t;
                    e = expq[i].pop_front();
                    t = tq[i].pop_front();
                    check($sformatf("pxl_out_%0d", i), pout[i], e.d);
                    check($sformatf("last_out_%0d", i), 32'(lout[i]), 32'(e.last));
                    check($sformatf("arrival_cycle_%0d", i), cyc, t);
                end
            end
        end
    end

    initial begin
        rst = 3'b111;
        vin = 3'b111;
        pin = '0;
        for (int i = 0; i < 3; i++) pin[i] = 32'h0000_0ABC;
        repeat (3) @(posedge clk);
        #1;
        rst = 3'b000;
        vin = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_pxl_out_%0d", i), pout[i], 32'd0);
            check($sformatf("reset_valid_out_%0d", i), 32'(vout[i]), 32'd0);
            check($sformatf("reset_last_out_%0d", i), 32'(lout[i]), 32'd0);
        end

        // Integer ramp, continuous valid.
        ramp_frame();
        model(0, 16, 16, 4, 3, 2, 0);
        check("model_ramp_count", expq[0].size(), 32'd256);
        check("model_ramp_first", expq[0][0].d, 32'd17);
        check("model_ramp_second", expq[0][1].d, 32'd19);
        check("model_ramp_final", expq[0][255].d, 32'd3255);
        check("model_ramp_final_last", 32'(expq[0][255].last), 32'd1);
        send(0, 16, 16, 2, 3, 1024, 0);
        drain(0);

        // Same ramp with bubbles.
        model(0, 16, 16, 4, 3, 2, 0);
        send(0, 16, 16, 2, 3, 1024, 1);
        drain(0);

        // Channel isolation: a large channel followed by an all-zero channel.
        frame.delete();
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 256; i++) frame.push_back((ch % 2 == 0) ? 32'h7F7F_FFFF : 32'h0);
        model(0, 16, 16, 4, 3, 2, 0);
        check("model_iso_ch0", expq[0][0].d, 32'h7F7F_FFFF);
        check("model_iso_ch1_row0", expq[0][64].d, 32'h0);
        send(0, 16, 16, 2, 3, 1024, 0);
        drain(0);

        // Reset at pixel 100 of channel 1, with valid_in held high through the reset cycle.
        ramp_frame();
        model(0, 16, 16, 4, 3, 2, 0);
        send(0, 16, 16, 2, 3, 356, 0);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        vin[0] = 1'b1;
        pin[0] = frame[356];
        @(posedge clk); #1;
        rst[0] = 1'b0;
        vin[0] = 1'b0;
        expq[0].delete();
        tq[0].delete();
        @(negedge clk);
        check("midreset_pxl_out", pout[0], 32'd0);
        check("midreset_valid_out", 32'(vout[0]), 32'd0);
        repeat (12) @(posedge clk);
        model(0, 16, 16, 4, 3, 2, 0);
        send(0, 16, 16, 2, 3, 1024, 0);
        drain(0);

        // Float ordering: -1.0 beats -2.0 and -inf.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(32'hFF80_0000);
        frame[0] = 32'hC000_0000;
        frame[5] = 32'hBF80_0000;
        model(1, 4, 4, 1, 3, 2, 1);
        check("model_fp_neg", expq[1][0].d, 32'hBF80_0000);
        send(1, 4, 4, 2, 3, 16, 0);
        drain(1);

        // Float ordering: +0 beats -0, positive NaN beats everything.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(32'hFF80_0000);
        frame[0]  = 32'h8000_0000;
        frame[1]  = 32'h8000_0000;
        frame[4]  = 32'h8000_0000;
        frame[5]  = 32'h0000_0000;
        frame[15] = 32'h7FC0_0000;
        model(1, 4, 4, 1, 3, 2, 1);
        check("model_fp_zero", expq[1][0].d, 32'h0000_0000);
        check("model_fp_nan", expq[1][3].d, 32'h7FC0_0000);
        send(1, 4, 4, 2, 3, 16, 0);
        drain(1);

        // K2 S2 4x4: outputs 5, 7, 13, 15.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(i);
        model(2, 4, 4, 1, 2, 2, 0);
        check("model_k2_0", expq[2][0].d, 32'd5);
        check("model_k2_1", expq[2][1].d, 32'd7);
        check("model_k2_2", expq[2][2].d, 32'd13);
        check("model_k2_3", expq[2][3].d, 32'd15);
        send(2, 4, 4, 2, 2, 16, 0);
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
